// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush controller.
// Holds the MDU state encoding, the x0 register index and the per-stage control bundle.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

    localparam logic [4:0] REG_X0 = '0;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic bubble_mem;
    } pipe_ctl_t;

    // A source operand depends on the EX destination only if it is actually read and is not x0.
    function automatic logic src_hit(input logic rd_en, input logic [4:0] rs, input logic [4:0] rd);
        return rd_en && (rs == rd) && (rd != REG_X0);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mdu_seq.sv
// MDU start/done handshake sequencer: issues a one-cycle start and holds the pipe
// until the iterative unit reports completion.
module mdu_seq
    import pipe_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic mdu_req_i,
    input  logic mem_wait_i,
    input  logic mdu_done_i,
    output logic mdu_start_o,
    output logic mdu_hold_o
);

    mdu_state_t state_q, state_d;

    always_comb begin
        mdu_start_o = (state_q == MDU_IDLE) && mdu_req_i && !mem_wait_i;
        mdu_hold_o  = mdu_start_o || (state_q == MDU_BUSY);
        state_d     = state_q;
        unique case (state_q)
            MDU_IDLE: if (mdu_start_o) state_d = MDU_BUSY;
            MDU_BUSY: if (mdu_done_i)  state_d = MDU_DONE;
            // EX/MEM captures the result here; the pipe is free to advance.
            MDU_DONE: state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: load-use, MDU sequencing, DRAM wait freeze with watchdog, EX redirect flush.
// Optional PERF_CNT_EN adds 32-bit stall and flush cycle counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_wr_i,
    input  logic        ex_rf_we_i,
    input  logic        ex_is_load_i,
    input  logic        ex_is_mdu_i,
    input  logic        ex_redirect_i,
    input  logic        mdu_done_i,
    output logic        mdu_start_o,
    input  logic        mem_req_i,
    input  logic        dram_ready_i,
    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        stall_ex_o,
    output logic        stall_mem_o,
    output logic        flush_id_o,
    output logic        flush_ex_o,
    output logic        bubble_mem_o,
`ifdef PERF_CNT_EN
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o,
`endif
    output logic        mem_timeout_o
);

    localparam int unsigned CNT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_WAIT_MAX);

    logic      mem_wait;
    logic      load_use;
    logic      mdu_hold;
    pipe_ctl_t ctl;

    assign mem_wait = mem_req_i & ~dram_ready_i;
    assign load_use = ex_valid_i & ex_is_load_i & ex_rf_we_i &
                      (src_hit(id_use_rs1_i, id_rs1_i, ex_wr_i) |
                       src_hit(id_use_rs2_i, id_rs2_i, ex_wr_i));

    mdu_seq u_mdu_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .mdu_req_i   (ex_valid_i & ex_is_mdu_i),
        .mem_wait_i  (mem_wait),
        .mdu_done_i  (mdu_done_i),
        .mdu_start_o (mdu_start_o),
        .mdu_hold_o  (mdu_hold)
    );

    // A DRAM wait freezes everything, so a pending redirect simply waits in EX until MEM drains.
    always_comb begin
        ctl = '0;
        if (mem_wait) begin
            ctl.stall_if  = 1'b1;
            ctl.stall_id  = 1'b1;
            ctl.stall_ex  = 1'b1;
            ctl.stall_mem = 1'b1;
        end else if (mdu_hold) begin
            ctl.stall_if   = 1'b1;
            ctl.stall_id   = 1'b1;
            ctl.stall_ex   = 1'b1;
            ctl.bubble_mem = 1'b1;
        end else if (ex_redirect_i) begin
            ctl.flush_id = 1'b1;
            ctl.flush_ex = 1'b1;
        end else if (load_use) begin
            ctl.stall_if = 1'b1;
            ctl.stall_id = 1'b1;
            ctl.flush_ex = 1'b1;
        end
    end

    assign stall_if_o   = ctl.stall_if;
    assign stall_id_o   = ctl.stall_id;
    assign stall_ex_o   = ctl.stall_ex;
    assign stall_mem_o  = ctl.stall_mem;
    assign flush_id_o   = ctl.flush_id;
    assign flush_ex_o   = ctl.flush_ex;
    assign bubble_mem_o = ctl.bubble_mem;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        wait_cnt_d = '0;
        if (mem_wait) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
        timeout_d = timeout_q | (wait_cnt_d == WAIT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_timeout_o = timeout_q;

`ifdef PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (ctl.stall_if)                 perf_stall_q <= perf_stall_q + 32'd1;
            if (ctl.flush_id || ctl.flush_ex) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1_i, id_rs2_i, ex_wr_i;
    logic        id_use_rs1_i, id_use_rs2_i, ex_valid_i, ex_rf_we_i, ex_is_load_i;
    logic        ex_is_mdu_i, ex_redirect_i, mdu_done_i, mdu_start_o, mem_req_i, dram_ready_i;
    logic        stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
    logic        flush_id_o, flush_ex_o, bubble_mem_o, mem_timeout_o;
`ifdef PERF_CNT_EN
    logic [31:0] perf_stall_cnt_o, perf_flush_cnt_o;
`endif

    pipeline_hazard_ctrl #(.MEM_WAIT_MAX(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .ex_valid_i(ex_valid_i), .ex_wr_i(ex_wr_i), .ex_rf_we_i(ex_rf_we_i),
        .ex_is_load_i(ex_is_load_i), .ex_is_mdu_i(ex_is_mdu_i), .ex_redirect_i(ex_redirect_i),
        .mdu_done_i(mdu_done_i), .mdu_start_o(mdu_start_o),
        .mem_req_i(mem_req_i), .dram_ready_i(dram_ready_i),
        .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_ex_o(stall_ex_o), .stall_mem_o(stall_mem_o),
        .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o), .bubble_mem_o(bubble_mem_o),
`ifdef PERF_CNT_EN
        .perf_stall_cnt_o(perf_stall_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o),
`endif
        .mem_timeout_o(mem_timeout_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: MDU phase (0 idle, 1 busy, 2 result cycle), consecutive wait count, sticky timeout.
    int       m_phase = 0;
    int       m_waits = 0;
    bit       m_to    = 1'b0;
    // Observed {stall_if,stall_id,stall_ex,stall_mem,flush_id,flush_ex,bubble_mem,mdu_start,mem_timeout}
    logic [8:0] obs;

    function automatic bit model_mem_wait();
        return mem_req_i && !dram_ready_i;
    endfunction

    function automatic bit model_start();
        return (m_phase == 0) && ex_valid_i && ex_is_mdu_i && !model_mem_wait();
    endfunction

    function automatic logic [8:0] model_out();
        bit lu;
        logic [6:0] c;
        lu = ex_valid_i && ex_is_load_i && ex_rf_we_i && (ex_wr_i != 5'd0) &&
             ((id_use_rs1_i && id_rs1_i == ex_wr_i) || (id_use_rs2_i && id_rs2_i == ex_wr_i));
        if (model_mem_wait())                  c = 7'b1111000;
        else if (model_start() || m_phase == 1) c = 7'b1110001;
        else if (ex_redirect_i)                c = 7'b0000110;
        else if (lu)                           c = 7'b1100010;
        else                                   c = 7'b0000000;
        return {c, model_start(), m_to};
    endfunction

    task automatic model_advance();
        bit st;
        st = model_start();
        case (m_phase)
            0: if (st) m_phase = 1;
            1: if (mdu_done_i) m_phase = 2;
            default: m_phase = 0;
        endcase
        if (model_mem_wait()) begin
            if (m_waits < 16) m_waits++;
            if (m_waits >= 16) m_to = 1'b1;
        end else begin
            m_waits = 0;
        end
    endtask

    // One clock: inputs are already applied; compare at the falling edge, advance model, return after rising edge.
    task automatic tick();
        logic [8:0] exp_v;
        @(negedge clk);
        if (!rst_n) begin
            m_phase = 0; m_waits = 0; m_to = 1'b0;
        end
        exp_v = model_out();
        obs = {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o, flush_id_o, flush_ex_o,
               bubble_mem_o, mdu_start_o, mem_timeout_o};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL model_cycle t=%0t got=%b expected=%b", $time, obs, exp_v);
        end
        if (rst_n) model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp_v);
        end
    endtask

    task automatic idle_inputs();
        id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0;
        ex_valid_i = 1'b0; ex_wr_i = 5'd0; ex_rf_we_i = 1'b0; ex_is_load_i = 1'b0;
        ex_is_mdu_i = 1'b0; ex_redirect_i = 1'b0; mdu_done_i = 1'b0;
        mem_req_i = 1'b0; dram_ready_i = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        chk("reset_outputs", 32'(obs), 32'd0);
        rst_n = 1'b1;
    endtask

    int starts, bubbles;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #1;
        do_reset();
        tick();

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_rf_we_i = 1'b1; ex_wr_i = 5'd5;
        id_rs1_i = 5'd5; id_use_rs1_i = 1'b1; id_rs2_i = 5'd1; id_use_rs2_i = 1'b1;
        tick();
        chk("load_use_stall", 32'(obs[8:1]), 32'b11000100);
        ex_valid_i = 1'b0;
        tick();
        chk("load_use_release", 32'(obs[8:1]), 32'd0);

        // x0 destination, and unread rs2
        ex_valid_i = 1'b1; ex_wr_i = 5'd0; id_rs1_i = 5'd0;
        tick();
        chk("x0_no_hazard", 32'(obs[8:1]), 32'd0);
        ex_wr_i = 5'd5; id_rs1_i = 5'd1; id_rs2_i = 5'd5; id_use_rs2_i = 1'b0;
        tick();
        chk("unused_rs2_no_hazard", 32'(obs[8:1]), 32'd0);

        // Redirect overrides load-use
        id_rs1_i = 5'd5; ex_redirect_i = 1'b1;
        tick();
        chk("redirect_over_load_use", 32'(obs[8:1]), 32'b00001100);
        idle_inputs();
        tick();

        // Divide: done arrives on the 32nd busy cycle
        ex_valid_i = 1'b1; ex_is_mdu_i = 1'b1; ex_rf_we_i = 1'b1; ex_wr_i = 5'd7;
        tick();
        chk("mdu_start_first", 32'(obs[1]), 32'd1);
        starts = int'(obs[1]); bubbles = int'(obs[2]);
        for (int i = 1; i <= 32; i++) begin
            mdu_done_i = (i == 32);
            tick();
            starts += int'(obs[1]); bubbles += int'(obs[2]);
        end
        mdu_done_i = 1'b0;
        tick();
        chk("mdu_done_cycle_free", 32'(obs[8:1]), 32'd0);
        idle_inputs();
        tick();
        chk("mdu_start_pulses", 32'(starts), 32'd1);
        chk("mdu_bubble_cycles", 32'(bubbles), 32'd33);

        // DRAM wait defers a redirect
        ex_valid_i = 1'b1; ex_redirect_i = 1'b1; mem_req_i = 1'b1; dram_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mem_wait_freeze", 32'(obs[8:1]), 32'b11110000);
        end
        dram_ready_i = 1'b1;
        tick();
        chk("redirect_after_wait", 32'(obs[8:1]), 32'b00001100);
        idle_inputs();
        tick();

        // Watchdog: 20 wait cycles
        mem_req_i = 1'b1; dram_ready_i = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 16) chk("timeout_not_yet", 32'(obs[0]), 32'd0);
            if (i == 17) chk("timeout_rises", 32'(obs[0]), 32'd1);
            if (i == 20) chk("timeout_stall_held", 32'(obs[8:5]), 32'hF);
        end
        idle_inputs();
        tick();
        chk("timeout_sticky", 32'(obs[0]), 32'd1);
        do_reset();
        tick();
        chk("timeout_cleared_by_reset", 32'(obs[0]), 32'd0);

        // Reset in the middle of an MDU operation
        ex_valid_i = 1'b1; ex_is_mdu_i = 1'b1;
        tick();
        tick();
        tick();
        chk("mdu_busy_hold", 32'(obs[2]), 32'd1);
        do_reset();
        tick();
        chk("mdu_after_reset", 32'(obs[8:1]), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ex_valid_i    = ($urandom % 4) != 0;
            ex_is_load_i  = ($urandom % 3) == 0;
            ex_is_mdu_i   = !ex_is_load_i && (($urandom % 8) == 0);
            ex_rf_we_i    = ($urandom % 5) != 0;
            ex_wr_i       = 5'($urandom % 8);
            id_rs1_i      = 5'($urandom % 8);
            id_rs2_i      = 5'($urandom % 8);
            id_use_rs1_i  = ($urandom % 3) != 0;
            id_use_rs2_i  = ($urandom % 2) != 0;
            ex_redirect_i = ($urandom % 6) == 0;
            mem_req_i     = ($urandom % 3) == 0;
            dram_ready_i  = ($urandom % 2) != 0;
            if ((i % 700) >= 680) begin
                mem_req_i = 1'b1; dram_ready_i = 1'b0;
            end
            mdu_done_i = (($urandom % 6) == 0) && !model_start();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_time_limit reached got=running expected=finished");
        $fatal(1);
    end

endmodule
